alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, meaning the operand, result and input byte width.
REQ-002 The block SHALL have parameter NB_OP, default 6, meaning the opcode width, taken from i_dato[NB_OP-1:0].
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1024, meaning the idle cycles allowed between frame bytes; 0 disables the timeout.
REQ-004 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-005 Port i_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port i_reset, input, 1 bit: asynchronous reset, active-low.
REQ-007 Port i_valid, input, 1 bit: i_dato holds a frame byte.
REQ-008 Port i_dato, input, NB_DATA bits: frame byte (A, then B, then opcode).
REQ-009 Port o_ready, output, 1 bit: a byte is accepted on an edge where i_valid and o_ready are both 1.
REQ-010 Port i_result_ready, input, 1 bit: the consumer accepts the result.
REQ-011 Port o_result, output, NB_DATA bits: ALU result.
REQ-012 Port o_valid, output, 1 bit: o_result and the flags are valid.
REQ-013 Port o_zero, output, 1 bit: o_result equals 0.
REQ-014 Port o_carry, output, 1 bit: ADD carry-out, or SUB borrow.
REQ-015 Port o_error, output, 1 bit: the opcode is not supported.
REQ-016 Port o_timeout, output, 1 bit: one-cycle pulse when a partial frame is discarded.

Function
REQ-017 The FSM SHALL have states WAIT_A, WAIT_B, WAIT_OP, EXEC and HOLD.
REQ-018 o_ready SHALL be 1 in WAIT_A, WAIT_B and WAIT_OP, and 0 in EXEC and HOLD; bytes presented while o_ready=0 SHALL be ignored.
REQ-019 An accepted byte SHALL be stored as A in WAIT_A (next state WAIT_B), as B in WAIT_B (next WAIT_OP), and as the opcode in WAIT_OP (next EXEC).
REQ-020 EXEC SHALL last exactly one cycle, registering o_result and all flags and entering HOLD, so o_valid rises one cycle after the opcode-accepting edge.
REQ-021 In HOLD, o_valid SHALL be 1 and o_result and the flags SHALL stay stable until an edge with i_result_ready=1, after which the state is WAIT_A and o_valid=0.
REQ-022 If i_result_ready is already 1 on entry to HOLD, o_valid SHALL be high for exactly one cycle.
REQ-023 Opcodes SHALL be: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010, SRA 000011; i_dato bits above NB_OP SHALL be ignored.
REQ-024 ADD/SUB SHALL be modulo 2^NB_DATA; ADD carry = bit NB_DATA of A+B; SUB carry = 1 when A<B unsigned.
REQ-025 For AND, OR, XOR, NOR, SRL and SRA, o_carry SHALL be 0.
REQ-026 Shifts SHALL shift A by B taken as unsigned; for B>=NB_DATA, SRL SHALL give 0 and SRA SHALL give all bits equal to A[NB_DATA-1].
REQ-027 An unsupported opcode SHALL give o_result=0, o_error=1, o_zero=1 and o_carry=0, still completing the o_valid handshake.
REQ-028 o_error SHALL be 0 for every supported opcode.
REQ-029 An idle counter SHALL clear on every accepted byte and on entry to WAIT_B.
REQ-030 The idle counter SHALL increment every cycle in WAIT_B or WAIT_OP without an accepted byte.
REQ-031 When the idle counter reaches TIMEOUT_CYC (nonzero) with no byte accepted in that cycle, the FSM SHALL return to WAIT_A and pulse o_timeout for one cycle.
REQ-032 A byte accepted in the same cycle as the timeout threshold SHALL win, and no timeout SHALL occur.
REQ-033 The idle counter SHALL not run in WAIT_A, EXEC or HOLD.

Reset
REQ-034 While i_reset=0, the block SHALL immediately force state WAIT_A, A=B=opcode=0, the idle counter to 0, and o_result, o_valid, o_zero, o_carry, o_error and o_timeout to 0.
REQ-035 o_ready SHALL become 1 after reset release.
REQ-036 A reset asserted mid-frame or in HOLD SHALL discard the partial frame or pending result, with no o_valid and no o_timeout.

Verification
REQ-037 The bench SHALL check: A=0x07, B=0x05, ADD -> o_result=0x0C, o_zero=0, o_carry=0, o_valid one cycle after the opcode edge.
REQ-038 The bench SHALL check: A=0xFF, B=0x01, ADD -> 0x00, o_zero=1, o_carry=1; A=0x03, B=0x05, SUB -> 0xFE, o_carry=1.
REQ-039 The bench SHALL check: A=0x80, B=0x03, SRA -> 0xF0; SRL -> 0x10; A=0x80, B=0x09, SRA -> 0xFF.
REQ-040 The bench SHALL check: opcode 000001 and opcode 111000 -> o_result=0x00, o_error=1, o_valid asserted.
REQ-041 The bench SHALL check, with i_result_ready=0 for 5 cycles and i_valid toggling: o_valid and the result held stable, all bytes ignored, and the next frame correct after release.
REQ-042 The bench SHALL check, with TIMEOUT_CYC=16, A accepted then 16 idle cycles: o_timeout pulse, and the next three bytes processed as a fresh A/B/opcode frame; a byte on the 16th cycle SHALL prevent the timeout.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Collects a three-byte command frame (operand A, operand B, opcode) over a
// valid/ready byte stream, evaluates it in a single ALU cycle and holds the
// result with its flags until the consumer takes it. A partially received
// frame is dropped, with a one-cycle o_timeout pulse, when the stream stalls
// too long between bytes.

module alu_cmd_sequencer #(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_dato,
  output logic               o_ready,
  input  logic               i_result_ready,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_valid,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_error,
  output logic               o_timeout
);

  // Frame / handshake states
  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  // Supported opcodes (MIPS-style function codes)
  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);

  // Shift amounts at or beyond the operand width saturate
  localparam logic [NB_DATA-1:0] SHIFT_LIM = NB_DATA'(NB_DATA);

  // Idle counter only needs to count up to TIMEOUT_CYC-1: the timeout fires
  // on the idle edge that would take it to TIMEOUT_CYC.
  localparam bit            TO_EN     = (TIMEOUT_CYC != 0);
  localparam int            CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int            TO_LAST_I = (TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_LAST_I);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  // ALU: returns {error, carry, result}
  function automatic logic [NB_DATA+1:0] alu_f(
    input logic [NB_DATA-1:0] a,
    input logic [NB_DATA-1:0] b,
    input logic [NB_OP-1:0]   op
  );
    logic [NB_DATA:0]   wide;
    logic [NB_DATA-1:0] res;
    logic               cry;
    logic               err;
    wide = {(NB_DATA+1){1'b0}};
    res  = {NB_DATA{1'b0}};
    cry  = 1'b0;
    err  = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[NB_DATA-1:0];
        cry  = wide[NB_DATA];
      end
      OP_SUB: begin
        res = a - b;
        cry = (a < b);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_SRL: begin
        if (b >= SHIFT_LIM) begin
          res = {NB_DATA{1'b0}};
        end else begin
          res = a >> b;
        end
      end
      OP_SRA: begin
        if (b >= SHIFT_LIM) begin
          res = {NB_DATA{a[NB_DATA-1]}};
        end else begin
          res = $signed(a) >>> b;
        end
      end
      default: begin
        res = {NB_DATA{1'b0}};
        err = 1'b1;
      end
    endcase
    return {err, cry, res};
  endfunction

  logic [2:0]         state_r;
  logic [2:0]         state_nxt_s;
  logic [NB_DATA-1:0] a_r;
  logic [NB_DATA-1:0] b_r;
  logic [NB_OP-1:0]   op_r;
  logic [CNT_W-1:0]   idle_cnt_r;
  logic [CNT_W-1:0]   idle_cnt_nxt_s;
  logic               ready_r;
  logic               ready_nxt_s;
  logic [NB_DATA-1:0] result_r;
  logic               valid_r;
  logic               zero_r;
  logic               carry_r;
  logic               error_r;
  logic               timeout_r;

  logic               accept_s;
  logic               waiting_s;
  logic               timeout_hit_s;
  logic [NB_DATA+1:0] alu_out_s;
  logic [NB_DATA-1:0] alu_res_s;
  logic               alu_carry_s;
  logic               alu_err_s;
  logic               alu_zero_s;

  // Handshake qualification and idle-timeout detection
  always_comb begin
    accept_s      = i_valid & ready_r;
    waiting_s     = (state_r == ST_WAIT_B) || (state_r == ST_WAIT_OP);
    if (TO_EN && waiting_s && !accept_s && (idle_cnt_r == TO_LAST)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Next-state logic; an accepted byte always beats the timeout
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_WAIT_A: begin
        if (accept_s) begin
          state_nxt_s = ST_WAIT_B;
        end else begin
          state_nxt_s = ST_WAIT_A;
        end
      end
      ST_WAIT_B: begin
        if (accept_s) begin
          state_nxt_s = ST_WAIT_OP;
        end else if (timeout_hit_s) begin
          state_nxt_s = ST_WAIT_A;
        end else begin
          state_nxt_s = ST_WAIT_B;
        end
      end
      ST_WAIT_OP: begin
        if (accept_s) begin
          state_nxt_s = ST_EXEC;
        end else if (timeout_hit_s) begin
          state_nxt_s = ST_WAIT_A;
        end else begin
          state_nxt_s = ST_WAIT_OP;
        end
      end
      ST_EXEC: state_nxt_s = ST_HOLD;
      ST_HOLD: begin
        if (i_result_ready) begin
          state_nxt_s = ST_WAIT_A;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_WAIT_A;
    endcase
  end

  // Idle counter: cleared by any accepted byte or timeout, frozen outside the wait states
  always_comb begin
    idle_cnt_nxt_s = idle_cnt_r;
    if (accept_s || timeout_hit_s) begin
      idle_cnt_nxt_s = CNT_ZERO;
    end else if (!waiting_s) begin
      idle_cnt_nxt_s = CNT_ZERO;
    end else if (TO_EN) begin
      idle_cnt_nxt_s = idle_cnt_r + CNT_ONE;
    end else begin
      idle_cnt_nxt_s = idle_cnt_r;
    end
  end

  // o_ready is registered from the next state so it lines up with state_r
  always_comb begin
    case (state_nxt_s)
      ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP: ready_nxt_s = 1'b1;
      default:                          ready_nxt_s = 1'b0;
    endcase
  end

  // ALU evaluation of the captured frame and flag extraction
  always_comb begin
    alu_out_s   = alu_f(a_r, b_r, op_r);
    alu_res_s   = alu_out_s[NB_DATA-1:0];
    alu_carry_s = alu_out_s[NB_DATA];
    alu_err_s   = alu_out_s[NB_DATA+1];
    alu_zero_s  = (alu_res_s == {NB_DATA{1'b0}});
  end

  // Control state: FSM, idle counter and ready flag
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r    <= ST_WAIT_A;
      idle_cnt_r <= CNT_ZERO;
      ready_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idle_cnt_r <= idle_cnt_nxt_s;
      ready_r    <= ready_nxt_s;
    end
  end

  // Frame capture: byte role is given by the state accepting it
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      a_r  <= {NB_DATA{1'b0}};
      b_r  <= {NB_DATA{1'b0}};
      op_r <= {NB_OP{1'b0}};
    end else if (accept_s) begin
      case (state_r)
        ST_WAIT_A:  a_r  <= i_dato;
        ST_WAIT_B:  b_r  <= i_dato;
        ST_WAIT_OP: op_r <= i_dato[NB_OP-1:0];
        default:    a_r  <= a_r;
      endcase
    end
  end

  // Result registers: loaded in EXEC, frozen through HOLD until the consumer takes them
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      result_r  <= {NB_DATA{1'b0}};
      valid_r   <= 1'b0;
      zero_r    <= 1'b0;
      carry_r   <= 1'b0;
      error_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_hit_s;
      case (state_r)
        ST_EXEC: begin
          valid_r  <= 1'b1;
          result_r <= alu_res_s;
          zero_r   <= alu_zero_s;
          carry_r  <= alu_carry_s;
          error_r  <= alu_err_s;
        end
        ST_HOLD: begin
          if (i_result_ready) begin
            valid_r <= 1'b0;
          end
        end
        default: valid_r <= 1'b0;
      endcase
    end
  end

  assign o_ready   = ready_r;
  assign o_result  = result_r;
  assign o_valid   = valid_r;
  assign o_zero    = zero_r;
  assign o_carry   = carry_r;
  assign o_error   = error_r;
  assign o_timeout = timeout_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: frame-level reference model feeding a
// scoreboard of expected results and timeout pulses, checked by an
// independent monitor on the falling clock edge.

module tb_alu_cmd_sequencer;

  localparam int NB = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_valid;
  logic [NB-1:0] i_dato;
  logic          o_ready;
  logic          i_result_ready;
  logic [NB-1:0] o_result;
  logic          o_valid;
  logic          o_zero;
  logic          o_carry;
  logic          o_error;
  logic          o_timeout;

  alu_cmd_sequencer #(.NB_DATA(NB), .NB_OP(6), .TIMEOUT_CYC(TO)) dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_dato        (i_dato),
    .o_ready       (o_ready),
    .i_result_ready(i_result_ready),
    .o_result      (o_result),
    .o_valid       (o_valid),
    .o_zero        (o_zero),
    .o_carry       (o_carry),
    .o_error       (o_error),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       e;
    int         vcyc;
  } exp_t;

  exp_t exp_q[$];
  int   to_q[$];
  exp_t cur;
  bit   holding = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   rr_mode = 0;   // 0: always ready, 1: never ready, 2: random
  int   pos = 0;       // model: next byte role (0=A, 1=B, 2=opcode)
  int   fa, fb;
  int   last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference ALU written with plain integer arithmetic
  function automatic exp_t model(input int a, input int b, input int opb, input int vcyc);
    exp_t e;
    int   op, r, sa;
    op = opb % 64;
    r = 0; e.c = 1'b0; e.e = 1'b0;
    case (op)
      32: begin r = a + b; e.c = (r > 255); r = r % 256; end
      34: begin e.c = (a < b); r = (a - b + 256) % 256; end
      36: r = a & b;
      37: r = a | b;
      38: r = a ^ b;
      39: r = 255 - (a | b);
      2:  r = (b >= 8) ? 0 : a / (1 << b);
      3: begin
        sa = (a >= 128) ? a - 256 : a;
        if (b >= 8) r = (a >= 128) ? 255 : 0;
        else        r = (sa >>> b) & 255;
      end
      default: begin r = 0; e.e = 1'b1; end
    endcase
    e.res  = r[7:0];
    e.z    = (r == 0);
    e.vcyc = vcyc;
    return e;
  endfunction

  // Consumer back-pressure
  initial begin
    i_result_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       i_result_ready = 1'b1;
        1:       i_result_ready = 1'b0;
        default: i_result_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expectations when results / timeout pulses appear
  initial begin
    int t;
    forever begin
      @(negedge clk);
      if (!i_reset) begin
        holding = 1'b0;
      end else begin
        if (o_timeout) begin
          if (to_q.size() == 0) chk("timeout_unexpected", o_timeout, 0);
          else begin t = to_q.pop_front(); chk("timeout_cycle", cyc, t); end
        end
        if (o_valid) begin
          if (!holding) begin
            if (exp_q.size() == 0) chk("valid_unexpected", o_valid, 0);
            else begin
              cur = exp_q.pop_front();
              chk("valid_latency", cyc, cur.vcyc);
              holding = 1'b1;
            end
          end
          if (holding) begin
            chk("result", o_result, cur.res);
            chk("zero",   o_zero,   cur.z);
            chk("carry",  o_carry,  cur.c);
            chk("error",  o_error,  cur.e);
          end
          if (i_result_ready) holding = 1'b0;
        end else if (holding) begin
          chk("valid_held", o_valid, 1);
          holding = 1'b0;
        end
      end
    end
  end

  // Present one byte after 'gap' idle cycles; updates the frame model
  task automatic send_byte(input int b, input int gap);
    int n, waited;
    i_valid = 1'b0;
    if (pos != 0 && gap >= TO) begin
      to_q.push_back(last_acc + TO + 1);
      pos = 0;
    end
    repeat (gap) begin @(posedge clk); #1; end
    i_valid = 1'b1;
    i_dato  = b[7:0];
    waited  = 0;
    @(negedge clk);
    while (!o_ready && waited < 300) begin waited++; @(negedge clk); end
    if (!o_ready) chk("accept_wait", o_ready, 1);
    n = cyc;
    @(posedge clk); #1;
    i_valid  = 1'b0;
    last_acc = n;
    case (pos)
      0: begin fa = b; pos = 1; end
      1: begin fb = b; pos = 2; end
      default: begin exp_q.push_back(model(fa, fb, b, n + 2)); pos = 0; end
    endcase
  endtask

  task automatic send_frame(input int a, input int b, input int op);
    send_byte(a, 0);
    send_byte(b, 0);
    send_byte(op, 0);
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || to_q.size() != 0 || holding) && w < 400) begin
      @(negedge clk); w++;
    end
    chk("drain_results", exp_q.size(), 0);
    chk("drain_timeouts", to_q.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    int w = 0;
    @(negedge clk);
    while (!o_valid && w < 20) begin @(negedge clk); w++; end
    chk(name, o_valid, 1);
  endtask

  task automatic pulse_reset();
    i_reset = 1'b0;
    pos = 0;
    #1;
    chk("async_reset_valid", o_valid, 0);
    chk("async_reset_ready", o_ready, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    i_reset = 1'b1;
  endtask

  initial begin
    int w, v, g;
    int ops[8];
    ops = '{32, 34, 36, 37, 38, 39, 2, 3};
    i_reset = 1'b0; i_valid = 1'b0; i_dato = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_result",  o_result,  0);
    chk("rst_valid",   o_valid,   0);
    chk("rst_zero",    o_zero,    0);
    chk("rst_carry",   o_carry,   0);
    chk("rst_error",   o_error,   0);
    chk("rst_timeout", o_timeout, 0);
    @(posedge clk); #1;
    i_reset = 1'b1;
    w = 0;
    @(negedge clk);
    while (!o_ready && w < 5) begin @(negedge clk); w++; end
    chk("ready_after_reset", o_ready, 1);
    @(posedge clk); #1;

    // Directed arithmetic / logic / shift / error frames
    send_frame(8'h07, 8'h05, 8'h20);
    send_frame(8'hFF, 8'h01, 8'h20);
    send_frame(8'h03, 8'h05, 8'h22);
    send_frame(8'h80, 8'h03, 8'h03);
    send_frame(8'h80, 8'h03, 8'h02);
    send_frame(8'h80, 8'h09, 8'h03);
    send_frame(8'h5A, 8'h3C, 8'h01);
    send_frame(8'h5A, 8'h3C, 8'h38);
    send_frame(8'h0F, 8'h33, 8'h24);
    send_frame(8'h0F, 8'h33, 8'h27);
    send_frame(8'h10, 8'h20, 8'hE0);   // upper opcode bits ignored -> ADD
    send_frame(8'h7F, 8'h08, 8'h02);
    drain();

    // Back-pressure: result held, bytes ignored while not ready
    rr_mode = 1;
    send_frame(8'h11, 8'h22, 8'h26);
    wait_valid("hold_valid");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("ready_low_in_hold", o_ready, 0);
      i_valid = (i % 2 == 0);
      i_dato  = 8'($urandom);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    rr_mode = 0;
    send_frame(8'h09, 8'h04, 8'h22);
    drain();

    // Idle timeouts and the accept-on-threshold boundary
    send_byte(8'h10, 0); send_byte(8'h20, 16); send_byte(8'h30, 0); send_byte(8'h20, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0);  send_byte(8'h20, 15);
    send_byte(8'h01, 0); send_byte(8'h02, 15); send_byte(8'h22, 0);
    send_byte(8'h05, 0); send_byte(8'h06, 0);  send_byte(8'h07, 20);
    send_byte(8'h08, 0); send_byte(8'h26, 0);
    drain();

    // Reset mid-frame: partial frame discarded, no output
    send_byte(8'h44, 0); send_byte(8'h55, 0);
    pulse_reset();
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    send_frame(8'h21, 8'h12, 8'h25);
    drain();

    // Reset while holding a result
    rr_mode = 1;
    send_frame(8'hAA, 8'h55, 8'h20);
    wait_valid("hold_before_reset");
    @(posedge clk); #1;
    pulse_reset();
    rr_mode = 0;
    send_frame(8'hC3, 8'h02, 8'h03);
    drain();

    // Randomized traffic with random back-pressure and occasional long gaps
    rr_mode = 2;
    for (int i = 0; i < 240; i++) begin
      if (pos == 2) begin
        if ($urandom_range(0, 4) == 0) v = int'($urandom_range(0, 255));
        else v = ops[$urandom_range(0, 7)] + 64 * int'($urandom_range(0, 3));
      end else if ($urandom_range(0, 2) == 0) begin
        v = int'($urandom_range(0, 10));
      end else begin
        v = int'($urandom_range(0, 255));
      end
      g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 2));
      send_byte(v, g);
    end
    rr_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
